// File: rtl/arbiter_pkg.sv
// Shared types and constants for the three-requester round-robin arbiter.
package arbiter_pkg;

  localparam int N_REQ = 3;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] oh;
    oh = '0;
    case (idx)
      SEL_A:   oh = 3'b001;
      SEL_B:   oh = 3'b010;
      SEL_C:   oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin winner select: searches one position after the
// last owner, so the last owner always has the lowest priority.
module rr_pick
  import arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] win,
  output logic       valid
);

  logic [1:0] p0, p1, p2;

  always_comb begin
    p0 = SEL_A;
    p1 = SEL_B;
    p2 = SEL_C;
    case (last)
      SEL_A: begin p0 = SEL_B; p1 = SEL_C; p2 = SEL_A; end
      SEL_B: begin p0 = SEL_C; p1 = SEL_A; p2 = SEL_B; end
      default: begin p0 = SEL_A; p1 = SEL_B; p2 = SEL_C; end
    endcase
  end

  always_comb begin
    win   = SEL_A;
    valid = 1'b0;
    if (|(req & idx_to_onehot(p0))) begin
      win   = p0;
      valid = 1'b1;
    end else if (|(req & idx_to_onehot(p1))) begin
      win   = p1;
      valid = 1'b1;
    end else if (|(req & idx_to_onehot(p2))) begin
      win   = p2;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/arbiter_3.sv
// Three-requester round-robin arbiter with per-grant hold limit.
// Handshake: a requester owns the resource while its gnt bit is high; it keeps
// req high to stay owner, and the resource raises done to end the transaction.
module arbiter_3
  import arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       arst,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       start,
  output logic       dbg_state
);

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;

  logic [1:0] pick_win;
  logic       pick_valid;
  logic       owner_req;
  logic       timeout;
  logic       release_c;

  // last_q equals the current owner while OWNED, so one picker serves both
  // the idle grant and the release hand-over (owner last in line).
  rr_pick u_rr_pick (
    .req   (req),
    .last  (last_q),
    .win   (pick_win),
    .valid (pick_valid)
  );

  assign owner_req = |(req & gnt_q);
  assign timeout   = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign release_c = done | ~owner_req | timeout;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= SEL_A;
      start_q <= 1'b0;
      cnt_q   <= '0;
      last_q  <= SEL_C;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    start_d = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_OWNED;
          gnt_d   = idx_to_onehot(pick_win);
          sel_d   = pick_win;
          start_d = 1'b1;
          cnt_d   = '0;
          last_d  = pick_win;
        end
      end
      ST_OWNED: begin
        if (release_c) begin
          if (pick_valid) begin
            gnt_d   = idx_to_onehot(pick_win);
            sel_d   = pick_win;
            start_d = 1'b1;
            cnt_d   = '0;
            last_d  = pick_win;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign busy      = |gnt_q;
  assign start     = start_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_arbiter_3.sv
// Directed and randomized checks of arbiter_3 against a behavioural model.
module tb_arbiter_3;

  localparam int MAX_HOLD = 8;
  localparam int STARVE   = 2 * MAX_HOLD + 2;

  logic       clk = 1'b0;
  logic       arst;
  logic [2:0] req;
  logic       done;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       start;
  logic       dbg_state;

  int vectors = 0;
  int miscompares = 0;

  // reference model state: owner -1 means nobody holds the grant
  int m_owner, m_last, m_cnt, m_sel;
  bit m_start;
  int wait_cnt[3];
  int max_wait;

  arbiter_3 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
    .clk       (clk),
    .arst      (arst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .sel       (sel),
    .busy      (busy),
    .start     (start),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (last + k) % 3;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 2; m_cnt = 0; m_sel = 0; m_start = 0;
  endtask

  task automatic model_grant(input int w);
    m_owner = w; m_last = w; m_sel = w; m_cnt = 0; m_start = 1;
  endtask

  task automatic model_update(input logic [2:0] r, input logic d);
    int w;
    m_start = 0;
    if (m_owner < 0) begin
      w = pick(r, m_last);
      if (w >= 0) model_grant(w);
    end else if (d || !r[m_owner] || m_cnt == MAX_HOLD - 1) begin
      w = pick(r, m_owner);
      if (w >= 0) model_grant(w);
      else m_owner = -1;
    end else begin
      m_cnt++;
    end
  endtask

  function automatic logic [2:0] m_gnt();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_gnt"}, 8'(gnt), 8'(m_gnt()));
    chk({tag, "_sel"}, 8'(sel), 8'(m_sel));
    chk({tag, "_busy"}, 8'(busy), 8'(m_owner >= 0));
    chk({tag, "_start"}, 8'(start), 8'(m_start));
  endtask

  task automatic step(input logic [2:0] r, input logic d, input string tag);
    req = r;
    done = d;
    @(posedge clk);
    model_update(r, d);
    #1;
    check_model(tag);
  endtask

  initial begin
    int starts;
    arst = 1'b1; req = 3'b000; done = 1'b0;
    model_reset();
    #12;
    chk("rst_gnt", 8'(gnt), 8'h00);
    chk("rst_sel", 8'(sel), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_start", 8'(start), 8'h00);
    @(negedge clk);
    arst = 1'b0;

    // all requesting, done each grant: A, B, C, A
    step(3'b111, 1'b0, "rr0"); chk("rr0_a", 8'(gnt), 8'h01); chk("rr0_st", 8'(start), 8'h01);
    step(3'b111, 1'b1, "rr1"); chk("rr1_b", 8'(gnt), 8'h02); chk("rr1_st", 8'(start), 8'h01);
    step(3'b111, 1'b1, "rr2"); chk("rr2_c", 8'(gnt), 8'h04); chk("rr2_st", 8'(start), 8'h01);
    step(3'b111, 1'b1, "rr3"); chk("rr3_a", 8'(gnt), 8'h01); chk("rr3_st", 8'(start), 8'h01);
    step(3'b000, 1'b1, "rr_idle"); chk("rr_idle_gnt", 8'(gnt), 8'h00);

    // hold limit: A alone for exactly MAX_HOLD cycles, then re-granted
    step(3'b001, 1'b0, "hold0"); chk("hold0_st", 8'(start), 8'h01);
    for (int i = 1; i < MAX_HOLD; i++) begin
      step(3'b001, 1'b0, "hold");
      chk("hold_gnt", 8'(gnt), 8'h01);
      chk("hold_nost", 8'(start), 8'h00);
    end
    step(3'b001, 1'b0, "rehold"); chk("rehold_gnt", 8'(gnt), 8'h01); chk("rehold_st", 8'(start), 8'h01);
    step(3'b000, 1'b0, "hold_end"); chk("hold_end_gnt", 8'(gnt), 8'h00);

    // owner B drops req with done while C requests: direct hand-over to C
    step(3'b010, 1'b0, "hb0"); chk("hb0_b", 8'(gnt), 8'h02);
    starts = 0;
    step(3'b100, 1'b1, "hb1"); chk("hb1_c", 8'(gnt), 8'h04); chk("hb1_sel", 8'(sel), 8'h02);
    starts += int'(start);
    step(3'b100, 1'b0, "hb2"); starts += int'(start);
    chk("hb_one_start", 8'(starts), 8'h01);

    // asynchronous reset mid-grant, then B wins from reset pointer
    req = 3'b100; done = 1'b0;
    #2; arst = 1'b1; #1;
    model_reset();
    chk("arst_gnt", 8'(gnt), 8'h00);
    chk("arst_busy", 8'(busy), 8'h00);
    chk("arst_sel", 8'(sel), 8'h00);
    #1; arst = 1'b0;
    step(3'b110, 1'b0, "post_rst"); chk("post_rst_b", 8'(gnt), 8'h02);

    // short C pulse while A owns is not remembered
    step(3'b000, 1'b0, "p0");
    step(3'b001, 1'b0, "p1"); chk("p1_a", 8'(gnt), 8'h01);
    step(3'b101, 1'b0, "p2");
    step(3'b001, 1'b0, "p3");
    step(3'b000, 1'b1, "p4"); chk("p4_idle", 8'(gnt), 8'h00);
    step(3'b000, 1'b0, "p5"); chk("p5_noc", 8'(gnt), 8'h00);

    // randomized traffic
    for (int i = 0; i < 3; i++) wait_cnt[i] = 0;
    max_wait = 0;
    for (int n = 0; n < 10000; n++) begin
      logic [2:0] r;
      logic d;
      r = 3'($urandom_range(0, 7));
      d = ($urandom_range(0, 3) == 0);
      step(r, d, "rnd");
      chk("rnd_onehot", 8'($onehot0(gnt)), 8'h01);
      chk("rnd_sel3", 8'(sel == 2'd3), 8'h00);
      for (int i = 0; i < 3; i++) begin
        if (r[i] && !gnt[i]) wait_cnt[i]++;
        else wait_cnt[i] = 0;
        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
    end
    chk("starve", 8'(max_wait > STARVE), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
